ppc_fetch_queue: RTL and testbench
==================================

// Module: ppc_fetch_queue
// PURPOSE
// - Instruction fetch front end for the single-cycle PPC core: owns the fetch PC, issues doubleword reads to
//   the instruction memory, splits each 64-bit word into big-endian 32-bit instructions, buffers them.
// - Feeds decode/execute through a valid/ready instruction port; the execute stage redirects it on taken branches.
// PARAMETERS
// - DEPTH     4      instruction-queue entries; power of 2, >= 2
// - RESET_PC  64'h0  fetch PC loaded on reset; bits [62:63] must be 0
// PORTS
// - clk            in   1       clock; all state updates on posedge
// - rst_n          in   1       reset, synchronous, active-low
// - memReqValid    out  1       doubleword read request
// - memReqReady    in   1       memory accepts request this cycle
// - memReqAddr     out  [0:60]  doubleword address (fetchPC[0:60])
// - memRspValid    in   1       read data valid
// - memRspData     in   [0:63]  read data; [0:31] = word at offset 0, [32:63] = word at offset 4
// - instValid      out  1       queue head valid
// - instReady      in   1       decode consumes head this cycle
// - inst           out  [0:31]  head instruction
// - instPC         out  [0:63]  address of head instruction
// - redirectValid  in   1       taken branch; flush and restart
// - redirectPC     in   [0:63]  new fetch address; bits [62:63] ignored, treated as 0
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): fetchPC=RESET_PC, state=IDLE, count=0; instValid=0, memReqValid=0 while rst_n=0.
// - States: IDLE (may issue), WAIT (one request outstanding), DROP (outstanding response must be discarded).
// - memReqValid = rst_n & (state==IDLE) & (DEPTH-count >= 2) & ~redirectValid. Request is accepted on
//   memReqValid & memReqReady -> WAIT. At most one outstanding request.
// - Response in WAIT: if fetchPC[61]==0, push {data[0:31] @fetchPC, data[32:63] @fetchPC+4}; else push only
//   data[32:63] @fetchPC. Then fetchPC = {fetchPC[0:60]+1, 3'b000}; state -> IDLE. 64-bit address wraps mod 2^64.
// - Response earliest in cycle after acceptance; non-bypass latency: response cycle N -> instValid at N+1.
// - Pop on instValid & instReady; same-cycle push and pop: count += pushes - pop; count never exceeds DEPTH.
// - Redirect (highest priority): queue flushed (count=0), fetchPC=redirectPC with [62:63]=0. A pop in the same
//   cycle still counts as consumed. WAIT with no same-cycle response -> DROP; WAIT with same-cycle response ->
//   response discarded, IDLE; DROP stays DROP; IDLE stays IDLE. No request is issued in the redirect cycle.
// - DROP: next response discarded -> IDLE; no push, fetchPC unchanged. Redirect-to-first-instValid >= 3 cycles.
// - memRspValid in IDLE is a protocol error: ignored, flagged by a simulation assertion.
// - Reset mid-operation overrides everything, including outstanding requests; a response arriving after
//   reset release while IDLE is ignored per rule above.
// CONFIGURATION
// - PPC_FETCH_BYPASS_EN defined: when queue is empty and a non-discarded response arrives, inst/instPC/instValid
//   are driven combinationally from memRspData the same cycle; if instReady, that word is not pushed
//   (only the second word, if any, is pushed). Redirect that cycle suppresses the bypass (instValid=0).
// - Undefined: no memory->decode combinational path; instValid is purely a function of registered queue state.
// STRUCTURE
// - Package ppc_fetch_pkg: ADDR_W=64, DWADDR_W=61, INST_W=32 constants; fetch_state_t enum {IDLE,WAIT,DROP};
//   function inst_half(data, sel) returning the 32-bit word selected by address bit 61.
// - Sub-module ppc_inst_fifo: DEPTH-entry circular FIFO of {inst, pc}, push of 0/1/2 entries per cycle,
//   pop of 0/1, synchronous flush; reports count. Fetch FSM and PC logic stay in ppc_fetch_queue.
// TESTING
// - Reset, RESET_PC=0, mem 1-cycle latency, instReady=1: requests addr 0,1,2; inst PCs 0,4,8,12 in order.
// - redirectPC=64'h104 (odd word): request addr 0x20, one push @0x104 (data[32:63]), next request addr 0x21.
// - Redirect while WAIT, response 3 cycles later: response dropped, no instValid from it; next req = new PC.
// - instReady=0 with DEPTH=4: queue fills to 4, memReqValid stays 0 at count>=3; one pop leaves it low until count<=2.
// - memReqReady held 0 for 5 cycles: memReqValid/memReqAddr stable, no state change; redirect mid-stall retargets addr.
// - PPC_FETCH_BYPASS_EN, empty queue, response 0x38600041_44000002 @PC 0: instValid same cycle, inst=0x38600041;
//   next cycle inst=0x44000002 @PC 4.

Source files
------------

// File: rtl/ppc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// ppc_fetch_pkg
// Shared constants, types and helpers for the PPC instruction fetch front end.
// Bit numbering follows the PowerPC convention: bit 0 is the MSB.
//   ADDR_W / DWADDR_W / INST_W : byte address, doubleword address, instruction widths
//   fetch_state_t              : fetch FSM states
//   fq_entry_t                 : one instruction-queue entry {inst, pc}
//   inst_half()                : picks the 32-bit word of a doubleword by address bit 61
// -----------------------------------------------------------------------------
package ppc_fetch_pkg;

    localparam int ADDR_W   = 64;
    localparam int DWADDR_W = 61;
    localparam int INST_W   = 32;

    // IDLE: may issue, WAIT: one request outstanding,
    // DROP: the outstanding response belongs to a flushed path.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [0:INST_W-1] inst;
        logic [0:ADDR_W-1] pc;
    } fq_entry_t;

    // Big-endian split: sel=0 -> word at offset 0 (bits 0..31), sel=1 -> offset 4.
    function automatic logic [0:INST_W-1] inst_half(input logic [0:2*INST_W-1] data,
                                                    input logic                sel);
        return sel ? data[INST_W:2*INST_W-1] : data[0:INST_W-1];
    endfunction

endpackage

// File: rtl/ppc_inst_fifo.sv
// -----------------------------------------------------------------------------
// ppc_inst_fifo
// DEPTH-entry circular instruction queue of {inst, pc}. Accepts 0, 1 or 2
// pushes and 0 or 1 pop per cycle; flush empties it synchronously.
// The producer guarantees there is room for every push and only pops when
// the head is valid.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   flush_i                  drop all entries this cycle (wins over push/pop)
//   push_cnt_i               number of entries to write (0..2), entry 0 first
//   push0_*_i / push1_*_i    the entries to write
//   pop_i                    consume the head entry
//   head_valid_o/inst_o/pc_o head entry
//   count_o                  current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module ppc_inst_fifo
    import ppc_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic [1:0]             push_cnt_i,
    input  logic [0:INST_W-1]      push0_inst_i,
    input  logic [0:ADDR_W-1]      push0_pc_i,
    input  logic [0:INST_W-1]      push1_inst_i,
    input  logic [0:ADDR_W-1]      push1_pc_i,
    input  logic                   pop_i,
    output logic                   head_valid_o,
    output logic [0:INST_W-1]      head_inst_o,
    output logic [0:ADDR_W-1]      head_pc_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);

    // NOTE: the storage array carries no reset; only pointers and count do.
    // Stale entries are never visible because head_valid_o follows count_q.
    always_ff @(posedge clk) begin
        if (push_cnt_i != 2'd0) begin
            mem_q[wr_ptr_q] <= {push0_inst_i, push0_pc_i};
        end
        if (push_cnt_i == 2'd2) begin
            mem_q[wr_ptr_nxt] <= {push1_inst_i, push1_pc_i};
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register sees the pre-edge values of its sources.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push_cnt_i);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_i);
            count_q  <= count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_i);
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_inst_o  = mem_q[rd_ptr_q].inst;
    assign head_pc_o    = mem_q[rd_ptr_q].pc;
    assign count_o      = count_q;

    // Producer contract: never pop an empty queue.
    assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && !head_valid_o));

endmodule

// File: rtl/ppc_fetch_queue.sv
// -----------------------------------------------------------------------------
// ppc_fetch_queue
// Instruction fetch front end of the single-cycle PPC core. Owns the fetch
// PC, issues one doubleword read at a time, splits each response into
// big-endian 32-bit instructions and buffers them in ppc_inst_fifo for decode.
// Taken branches from execute flush the queue and restart fetch.
//
// Configuration macro: PPC_FETCH_BYPASS_EN
//   defined   : a response arriving at an empty queue is forwarded to the
//               decode port in the same cycle.
//   undefined : instValid/inst/instPC come from registered queue state only.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   memReqValid/Ready, memReqAddr  doubleword read request (fetchPC[0:60])
//   memRspValid, memRspData        read data, [0:31] = offset 0, [32:63] = offset 4
//   instValid/Ready, inst, instPC  head of the instruction queue to decode
//   redirectValid, redirectPC      taken-branch flush and new fetch address
// -----------------------------------------------------------------------------
module ppc_fetch_queue
    import ppc_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [0:63] RESET_PC = 64'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         memReqValid,
    input  logic         memReqReady,
    output logic [0:60]  memReqAddr,
    input  logic         memRspValid,
    input  logic [0:63]  memRspData,
    output logic         instValid,
    input  logic         instReady,
    output logic [0:31]  inst,
    output logic [0:63]  instPC,
    input  logic         redirectValid,
    input  logic [0:63]  redirectPC
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [0:ADDR_W-1] fetch_pc_q, fetch_pc_d;

    logic [CNT_W-1:0]  count;
    logic              fifo_valid;
    logic [0:INST_W-1] fifo_inst;
    logic [0:ADDR_W-1] fifo_pc;
    logic              fifo_pop;

    logic              rsp_accept;
    logic              rsp_two;
    logic [0:INST_W-1] rsp_word0, rsp_word1;
    logic [0:ADDR_W-1] rsp_pc1;

    logic [1:0]        push_cnt;
    logic [0:INST_W-1] push0_inst, push1_inst;
    logic [0:ADDR_W-1] push0_pc, push1_pc;

    // The low two bits of a redirect target are architecturally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirectPC[62:63];

    // ---------------------------------------------------------------------
    // Request side. Issue only with room for a full doubleword (two slots),
    // so a response can always be pushed without back-pressuring memory.
    // memReqValid is combinational in redirectValid so that nothing is
    // issued from the stale path in the redirect cycle.
    // ---------------------------------------------------------------------
    assign memReqValid = rst_n && (state_q == IDLE) &&
                         (count <= CNT_W'(DEPTH - 2)) && !redirectValid;
    assign memReqAddr  = fetch_pc_q[0:DWADDR_W-1];

    // ---------------------------------------------------------------------
    // Response side. An odd-word fetch PC (bit 61 set) means the word at
    // offset 0 lies before the branch target and is skipped.
    // ---------------------------------------------------------------------
    assign rsp_accept = rst_n && (state_q == WAIT) && memRspValid && !redirectValid;
    assign rsp_two    = !fetch_pc_q[61];
    assign rsp_word0  = inst_half(memRspData, fetch_pc_q[61]);
    assign rsp_word1  = inst_half(memRspData, 1'b1);
    assign rsp_pc1    = fetch_pc_q + 64'd4;

`ifdef PPC_FETCH_BYPASS_EN
    logic bypass;
    assign bypass = rsp_accept && !fifo_valid;
`endif

    // NOTE: every signal driven here gets a default at the top of the block,
    // so no path through the branches leaves it unassigned (no latches).
    always_comb begin
        push_cnt   = 2'd0;
        push0_inst = rsp_word0;
        push0_pc   = fetch_pc_q;
        push1_inst = rsp_word1;
        push1_pc   = rsp_pc1;

`ifdef PPC_FETCH_BYPASS_EN
        instValid = rst_n && (fifo_valid || bypass);
        inst      = fifo_valid ? fifo_inst : rsp_word0;
        instPC    = fifo_valid ? fifo_pc   : fetch_pc_q;
        fifo_pop  = rst_n && fifo_valid && instReady;

        if (rsp_accept) begin
            if (bypass && instReady) begin
                // First word went straight to decode; only queue the second.
                push_cnt   = rsp_two ? 2'd1 : 2'd0;
                push0_inst = rsp_word1;
                push0_pc   = rsp_pc1;
            end else begin
                push_cnt = rsp_two ? 2'd2 : 2'd1;
            end
        end
`else
        instValid = rst_n && fifo_valid;
        inst      = fifo_inst;
        instPC    = fifo_pc;
        fifo_pop  = rst_n && fifo_valid && instReady;

        if (rsp_accept) begin
            push_cnt = rsp_two ? 2'd2 : 2'd1;
        end
`endif
    end

    // ---------------------------------------------------------------------
    // Fetch FSM and PC next-state. Redirect has priority over everything
    // except reset: it always retargets the PC and never lets a response in.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;

        unique case (state_q)
            IDLE: begin
                if (memReqValid && memReqReady) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (memRspValid) begin
                    // Response consumed (or discarded on redirect): idle again.
                    state_d = IDLE;
                    if (!redirectValid) begin
                        fetch_pc_d = {fetch_pc_q[0:DWADDR_W-1] + DWADDR_W'(1), 3'b000};
                    end
                end else if (redirectValid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // The stale response is discarded whether or not a new
                // redirect arrives with it; waiting longer would deadlock.
                if (memRspValid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirectValid) begin
            fetch_pc_d = {redirectPC[0:61], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= {RESET_PC[0:61], 2'b00};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ppc_inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirectValid),
        .push_cnt_i   (push_cnt),
        .push0_inst_i (push0_inst),
        .push0_pc_i   (push0_pc),
        .push1_inst_i (push1_inst),
        .push1_pc_i   (push1_pc),
        .pop_i        (fifo_pop),
        .head_valid_o (fifo_valid),
        .head_inst_o  (fifo_inst),
        .head_pc_o    (fifo_pc),
        .count_o      (count)
    );

    // A response with no request outstanding is a memory protocol error.
    assert property (@(posedge clk) disable iff (!rst_n) !(memRspValid && state_q == IDLE));

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_ppc_fetch_queue
// Directed bench for ppc_fetch_queue (DEPTH=4, RESET_PC=0). Inputs change 1ns
// after the rising edge; outputs are sampled on the falling edge. A small
// memory responder returns a fixed pattern a programmable number of cycles
// after each accepted request. Cycle numbers below count from reset release.
// -----------------------------------------------------------------------------
module tb_ppc_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memReqValid;
    logic        memReqReady;
    logic [0:60] memReqAddr;
    logic        memRspValid = 1'b0;
    logic [0:63] memRspData  = '0;
    logic        instValid;
    logic        instReady;
    logic [0:31] inst;
    logic [0:63] instPC;
    logic        redirectValid;
    logic [0:63] redirectPC;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ppc_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memReqValid   (memReqValid),
        .memReqReady   (memReqReady),
        .memReqAddr    (memReqAddr),
        .memRspValid   (memRspValid),
        .memRspData    (memRspData),
        .instValid     (instValid),
        .instReady     (instReady),
        .inst          (inst),
        .instPC        (instPC),
        .redirectValid (redirectValid),
        .redirectPC    (redirectPC)
    );

    // Memory image: doubleword 0 holds the "li r3,0x41 ; sc" pair, every
    // other word holds 0x6000_0000 + its byte address.
    function automatic logic [31:0] word_at(input logic [63:0] b);
        return 32'h6000_0000 + b[31:0];
    endfunction

    function automatic logic [0:63] mem_dw(input logic [0:60] a);
        logic [63:0] b;
        b = {a, 3'b000};
        if (a == 61'd0) return 64'h38600041_44000002;
        return {word_at(b), word_at(b + 64'd4)};
    endfunction

    // Memory responder: a request seen on the falling edge is accepted at the
    // next rising edge; the response is driven rsp_delay cycles later.
    logic        fire_s    = 1'b0;
    logic [0:60] addr_s    = '0;
    logic        pend      = 1'b0;
    int          pend_left = 0;
    logic [0:60] pend_addr = '0;
    int          rsp_delay = 1;

    always @(negedge clk) begin
        fire_s = memReqValid & memReqReady;
        addr_s = memReqAddr;
    end

    always @(posedge clk) begin
        #1;
        memRspValid = 1'b0;
        memRspData  = '0;
        if (fire_s) begin
            pend      = 1'b1;
            pend_left = rsp_delay;
            pend_addr = addr_s;
        end
        if (pend) begin
            if (pend_left <= 1) begin
                memRspValid = 1'b1;
                memRspData  = mem_dw(pend_addr);
                pend        = 1'b0;
            end else begin
                pend_left = pend_left - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        memReqReady   = 1'b1;
        instReady     = 1'b1;
        redirectValid = 1'b0;
        redirectPC    = '0;

        smp();
        check("rst_req_valid", memReqValid, 0);
        check("rst_inst_valid", instValid, 0);
        adv();
        adv();
        rst_n = 1'b1;

        // C2: first request to doubleword 0, queue empty.
        smp();
        check("c2_req_valid", memReqValid, 1);
        check("c2_req_addr", memReqAddr, 0);
        check("c2_inst_valid", instValid, 0);

`ifdef PPC_FETCH_BYPASS_EN
        // C3: response reaches decode in the same cycle through the bypass.
        adv(); smp();
        check("byp_c3_valid", instValid, 1);
        check("byp_c3_inst", inst, 64'h38600041);
        check("byp_c3_pc", instPC, 0);
        // C4: only the second word was queued.
        adv(); smp();
        check("byp_c4_valid", instValid, 1);
        check("byp_c4_inst", inst, 64'h44000002);
        check("byp_c4_pc", instPC, 4);
        check("byp_c4_req_valid", memReqValid, 1);
        check("byp_c4_req_addr", memReqAddr, 1);
        // C5: empty queue with a response, but a redirect suppresses the bypass.
        adv(); redirectValid = 1'b1; redirectPC = 64'h40; smp();
        check("byp_c5_suppressed", instValid, 0);
        check("byp_c5_req_valid", memReqValid, 0);
        adv(); redirectValid = 1'b0; smp();
        check("byp_c6_inst_valid", instValid, 0);
        check("byp_c6_req_addr", memReqAddr, 8);
`else
        // Sequential fetch from reset: addresses 0,1,2,3; PCs 0,4,8,...
        adv(); smp();
        check("c3_req_busy", memReqValid, 0);
        check("c3_no_bypass", instValid, 0);
        adv(); smp();
        check("c4_valid", instValid, 1);
        check("c4_pc", instPC, 0);
        check("c4_inst", inst, 64'h38600041);
        check("c4_req_valid", memReqValid, 1);
        check("c4_req_addr", memReqAddr, 1);
        adv(); smp();
        check("c5_pc", instPC, 4);
        check("c5_inst", inst, 64'h44000002);
        adv(); smp();
        check("c6_pc", instPC, 8);
        check("c6_inst", inst, 64'h60000008);
        check("c6_req_addr", memReqAddr, 2);
        adv(); smp();
        check("c7_pc", instPC, 12);
        adv(); smp();
        check("c8_pc", instPC, 16);
        check("c8_req_valid", memReqValid, 1);
        check("c8_req_addr", memReqAddr, 3);

        // C9: redirect to odd word 0x104 while the response for dw 3 arrives.
        adv(); redirectValid = 1'b1; redirectPC = 64'h104; smp();
        check("c9_req_blocked", memReqValid, 0);
        check("c9_pop_pc", instPC, 20);
        adv(); redirectValid = 1'b0; smp();
        check("c10_flushed", instValid, 0);
        check("c10_req_valid", memReqValid, 1);
        check("c10_req_addr", memReqAddr, 64'h20);
        adv(); smp();
        check("c11_inst_valid", instValid, 0);
        adv(); smp();
        check("c12_valid", instValid, 1);
        check("c12_pc", instPC, 64'h104);
        check("c12_inst", inst, 64'h60000104);
        check("c12_req_addr", memReqAddr, 64'h21);
        adv(); smp();
        check("c13_single_push", instValid, 0);
        adv(); smp();
        check("c14_pc", instPC, 64'h108);
        check("c14_req_addr", memReqAddr, 64'h22);
        rsp_delay = 3;

        // C15: redirect while WAIT with no response -> DROP.
        adv(); redirectValid = 1'b1; redirectPC = 64'h200; smp();
        check("c15_pc", instPC, 64'h10C);
        check("c15_req_blocked", memReqValid, 0);
        adv(); redirectValid = 1'b0; smp();
        check("c16_drop_req", memReqValid, 0);
        check("c16_drop_inst", instValid, 0);
        adv(); smp();
        check("c17_stale_rsp", memRspValid, 1);
        check("c17_drop_req", memReqValid, 0);
        check("c17_drop_inst", instValid, 0);
        rsp_delay = 1;
        adv(); smp();
        check("c18_req_valid", memReqValid, 1);
        check("c18_req_addr", memReqAddr, 64'h40);
        check("c18_no_push", instValid, 0);
        adv(); smp();
        check("c19_inst_valid", instValid, 0);

        // Back-pressure from decode: queue fills to DEPTH.
        adv(); instReady = 1'b0; smp();
        check("c20_pc", instPC, 64'h200);
        check("c20_inst", inst, 64'h60000200);
        check("c20_req_addr", memReqAddr, 64'h41);
        adv(); smp();
        check("c21_hold_pc", instPC, 64'h200);
        adv(); smp();
        check("c22_full_req", memReqValid, 0);
        adv(); instReady = 1'b1; smp();
        check("c23_full_req", memReqValid, 0);
        adv(); instReady = 1'b0; smp();
        check("c24_cnt3_req", memReqValid, 0);
        check("c24_pc", instPC, 64'h204);
        adv(); instReady = 1'b1; memReqReady = 1'b0; smp();
        check("c25_cnt3_req", memReqValid, 0);

        // Memory stall: request held stable for five cycles.
        adv(); instReady = 1'b0; smp();
        check("c26_req_valid", memReqValid, 1);
        check("c26_req_addr", memReqAddr, 64'h42);
        check("c26_pc", instPC, 64'h208);
        for (int i = 0; i < 4; i++) begin
            adv(); smp();
            check("stall_req_valid", memReqValid, 1);
            check("stall_req_addr", memReqAddr, 64'h42);
            check("stall_pc", instPC, 64'h208);
        end

        // Redirect mid-stall retargets the pending request.
        adv(); redirectValid = 1'b1; redirectPC = 64'h3000; smp();
        check("c31_req_blocked", memReqValid, 0);
        adv(); redirectValid = 1'b0; memReqReady = 1'b1; instReady = 1'b1; smp();
        check("c32_req_valid", memReqValid, 1);
        check("c32_req_addr", memReqAddr, 64'h600);
        check("c32_flushed", instValid, 0);
        adv(); smp();
        check("c33_inst_valid", instValid, 0);
        adv(); smp();
        check("c34_valid", instValid, 1);
        check("c34_pc", instPC, 64'h3000);
        check("c34_inst", inst, 64'h60003000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
